// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, 1 Hz prescaler and run/pause/lap FSM
// for the seconds counter and 7-seg display path.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the display).
// With the macro undefined, the lap key only clears from PAUSE and disp_hold is tied 0.

// Per-button conditioning: 2-FF sync, counted debounce, registered press pulse.
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // Level flips only after DEBOUNCE_CYC consecutive mismatching samples.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) lvl_d = sync2_q;
      else                                cnt_d = cnt_q + 1'b1;
    end
  end

  // Sync chain, debounce state and press pulse; released (1) after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= lvl_q & ~lvl_d;
    end
  end

  assign press_o = press_q;
endmodule

module stopwatch_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_HZ      = 1,
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_n,
  input  logic       btn_lap_n,
  output logic       tick_out,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

  // Lane 0 = start key, lane 1 = lap key.
  logic [1:0] btn_n, press;
  assign btn_n = {btn_lap_n, btn_start_n};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_n_i(btn_n[g]),
      .press_o(press[g])
    );
  end

  logic s_ev, l_ev;
  assign s_ev = press[0];
  assign l_ev = press[1];

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          run_q;

  // Next state, prescaler advance and output pulses; start wins over lap.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    // Prescaler runs off the current state, so a wrap on the exit cycle still ticks.
    if (state_q == RUN || state_q == LAP) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    case (state_q)
      IDLE:  if (s_ev) state_d = RUN;
      RUN: begin
        if (s_ev) state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (l_ev) state_d = LAP;
`endif
      end
      LAP: begin
        if (s_ev)      state_d = PAUSE;
        else if (l_ev) state_d = RUN;
      end
      PAUSE: begin
        if (s_ev) state_d = RUN;
        else if (l_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          presc_d = '0;
        end
      end
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == RUN) || (state_d == LAP);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic hold_q;
  // Display freeze mirrors the LAP state, registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 1'b0;
    else     hold_q <= (state_d == LAP);
  end
  assign disp_hold = hold_q;
`else
  assign disp_hold = 1'b0;
`endif

  assign tick_out = tick_q;
  assign cnt_clr  = clr_q;
  assign running  = run_q;
  assign state    = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=100, TICK_HZ=10, DEBOUNCE_CYC=4.
// A press asserted right after a sample reaches the state register 7 cycles later.
module tb_stopwatch_ctrl;
  logic       clk = 1'b0;
  logic       rst, btn_start_n, btn_lap_n;
  logic       tick_out, cnt_clr, disp_hold, running;
  logic [1:0] state;

  stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start_n(btn_start_n),
    .btn_lap_n  (btn_lap_n),
    .tick_out   (tick_out),
    .cnt_clr    (cnt_clr),
    .disp_hold  (disp_hold),
    .running    (running),
    .state      (state)
  );

  always #5 clk = ~clk;

`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] LAP_ST   = 2'b11;
  localparam logic       LAP_HOLD = 1'b1;
`else
  localparam logic [1:0] LAP_ST   = 2'b01;
  localparam logic       LAP_HOLD = 1'b0;
`endif

  typedef struct {
    logic       s;
    logic       l;
    logic [1:0] st;
    logic       run;
    logic       hold;
    int         clr;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  int tick_cnt = 0, clr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick_out) tick_cnt++;
    if (cnt_clr)  clr_cnt++;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string name,
                            output int n);
    n = 0;
    while (state != tgt && n < budget) begin
      step();
      n++;
    end
    chk({name, " reached"}, int'(state), int'(tgt));
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_out && n < budget);
  endtask

  // Hold the selected keys low 8 cycles, then release for 12.
  task automatic press(input logic s, input logic l);
    clr_cnt     = 0;
    btn_start_n = ~s;
    btn_lap_n   = ~l;
    repeat (8) step();
    btn_start_n = 1'b1;
    btn_lap_n   = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    vec_t tbl[11];
    int   n;

    tbl[0]  = '{s:1'b0, l:1'b1, st:2'b00,  run:1'b0, hold:1'b0,     clr:0};
    tbl[1]  = '{s:1'b1, l:1'b0, st:2'b01,  run:1'b1, hold:1'b0,     clr:0};
    tbl[2]  = '{s:1'b0, l:1'b1, st:LAP_ST, run:1'b1, hold:LAP_HOLD, clr:0};
    tbl[3]  = '{s:1'b0, l:1'b1, st:2'b01,  run:1'b1, hold:1'b0,     clr:0};
    tbl[4]  = '{s:1'b1, l:1'b0, st:2'b10,  run:1'b0, hold:1'b0,     clr:0};
    tbl[5]  = '{s:1'b1, l:1'b0, st:2'b01,  run:1'b1, hold:1'b0,     clr:0};
    tbl[6]  = '{s:1'b1, l:1'b0, st:2'b10,  run:1'b0, hold:1'b0,     clr:0};
    tbl[7]  = '{s:1'b0, l:1'b1, st:2'b00,  run:1'b0, hold:1'b0,     clr:1};
    tbl[8]  = '{s:1'b1, l:1'b1, st:2'b01,  run:1'b1, hold:1'b0,     clr:0};
    tbl[9]  = '{s:1'b1, l:1'b0, st:2'b10,  run:1'b0, hold:1'b0,     clr:0};
    tbl[10] = '{s:1'b0, l:1'b1, st:2'b00,  run:1'b0, hold:1'b0,     clr:1};

    rst = 1'b1; btn_start_n = 1'b1; btn_lap_n = 1'b1;
    step(); step();
    chk("reset state", int'(state), 0);
    chk("reset tick", int'(tick_out), 0);
    chk("reset clr", int'(cnt_clr), 0);
    chk("reset hold", int'(disp_hold), 0);
    chk("reset running", int'(running), 0);
    rst = 1'b0;

    // Start pin bouncing every cycle never satisfies the debounce.
    tick_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      btn_start_n = i[0];
      step();
    end
    btn_start_n = 1'b1;
    repeat (12) step();
    chk("bounce state", int'(state), 0);
    chk("bounce ticks", tick_cnt, 0);

    // Start press, latency and tick cadence.
    btn_start_n = 1'b0;
    wait_state(2'b01, 20, "t1 run", n);
    chk("t1 latency bound", int'(n <= 8), 1);
    chk("t1 latency", n, 7);
    btn_start_n = 1'b1;
    wait_tick(30, n);
    chk("t1 first tick", n, 10);
    wait_tick(30, n);
    chk("t1 tick period", n, 10);
    step();
    chk("t1 tick width", int'(tick_out), 0);
    wait_tick(30, n);
    chk("t3 sync tick", n, 9);

    // Pause at prescaler 5, hold 50 cycles, resume: tick 5 cycles after re-entry.
    repeat (8) step();
    btn_start_n = 1'b0;
    wait_state(2'b10, 20, "t3 pause", n);
    chk("t3 pause latency", n, 7);
    btn_start_n = 1'b1;
    tick_cnt = 0;
    repeat (50) step();
    chk("t3 pause ticks", tick_cnt, 0);
    chk("t3 pause running", int'(running), 0);
    chk("t3 pause state", int'(state), 2);
    btn_start_n = 1'b0;
    wait_state(2'b01, 20, "t3 resume", n);
    btn_start_n = 1'b1;
    wait_tick(30, n);
    chk("t3 resume tick", n, 5);

    // PAUSE + lap clears; then start and lap together from IDLE.
    press(1'b1, 1'b0);
    chk("t5 pause state", int'(state), 2);
    clr_cnt = 0;
    btn_lap_n = 1'b0;
    wait_state(2'b00, 20, "t5 idle", n);
    chk("t5 clr with idle", int'(cnt_clr), 1);
    btn_lap_n = 1'b1;
    repeat (12) step();
    chk("t5 clr pulses", clr_cnt, 1);
    chk("t5 idle running", int'(running), 0);
    btn_start_n = 1'b0; btn_lap_n = 1'b0;
    wait_state(2'b01, 20, "t5 both run", n);
    btn_start_n = 1'b1; btn_lap_n = 1'b1;
    wait_tick(30, n);
    chk("t5 cleared prescaler", n, 10);

    // Lap press in RUN: freeze with LAP enabled, ignored otherwise; ticks keep coming.
    press(1'b0, 1'b1);
    chk("t4 lap state", int'(state), int'(LAP_ST));
    chk("t4 lap hold", int'(disp_hold), int'(LAP_HOLD));
    chk("t4 lap running", int'(running), 1);
    tick_cnt = 0;
    repeat (20) step();
    chk("t4 lap ticks", tick_cnt, 2);
    press(1'b0, 1'b1);
    chk("t4 back state", int'(state), 1);
    chk("t4 back hold", int'(disp_hold), 0);

    // Asynchronous reset between clock edges while running.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6 rst state", int'(state), 0);
    chk("t6 rst running", int'(running), 0);
    chk("t6 rst tick", int'(tick_out), 0);
    chk("t6 rst clr", int'(cnt_clr), 0);
    chk("t6 rst hold", int'(disp_hold), 0);
    step();
    rst = 1'b0;
    step();

    // Table of key presses from IDLE through the FSM.
    for (int i = 0; i < 11; i++) begin
      press(tbl[i].s, tbl[i].l);
      chk($sformatf("vec%0d state", i), int'(state), int'(tbl[i].st));
      chk($sformatf("vec%0d running", i), int'(running), int'(tbl[i].run));
      chk($sformatf("vec%0d hold", i), int'(disp_hold), int'(tbl[i].hold));
      chk($sformatf("vec%0d clr", i), clr_cnt, tbl[i].clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
